colorizer_mc: RTL and testbench
===============================

# colorizer_mc

Pipelined, parametrised pixel colorizer for the VGA path. Merges NUM_ICONS icon layers, with fixed priority and a zero-is-transparent rule, over a world-map pixel that is resolved through a run-time-writable palette. Sits between the icon/world-map pixel sources and the VGA output pins. Replaces the two-icon combinational colorizer, adding registered outputs, a loadable palette, a per-icon hit indication and optional icon blinking.

## Interface
- NUM_ICONS, 2: number of icon layers; index 0 has highest priority; range 1–8.
- COLOR_W, 4: bits per colour channel; a pixel is 3*COLOR_W bits, packed {R,G,B}.
- WORLD_W, 2: world-pixel code width; palette depth is 2**WORLD_W.
- BLINK_PERIOD, 25_000_000: cycles per blink half-period; minimum 2.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- video_on  in  1  display-active qualifier from the DTG.
- world_pixel  in  WORLD_W  world-map code for the current pixel.
- icon_pixels  in  NUM_ICONS*3*COLOR_W  icon colours; icon i occupies bits [i*3*COLOR_W +: 3*COLOR_W]; all-zero means transparent.
- blink_mask  in  NUM_ICONS  per-icon blink enable.
- pal_we  in  1  palette write strobe.
- pal_addr  in  WORLD_W  palette entry written.
- pal_wdata  in  3*COLOR_W  palette write data.
- VGA_R / VGA_G / VGA_B  out  COLOR_W each  registered colour outputs.
- icon_hit  out  NUM_ICONS  one-hot winning icon, aligned with the VGA outputs; all-zero when the map wins or video is off.

## Operation
- Palette: 2**WORLD_W registers. Reset values, in COLOR_W=4 terms, left-justified for other widths: entry 0 = 0xFFF (white), 1 = 0x000 (black), 2 = 0x840 (brown), 3 = 0x0F0 (green). Entries ≥4 reset to 0.
- Palette write: on a clk edge with pal_we=1, pal_wdata is written to pal_addr. A lookup of the same address in the same cycle returns the old value; the new value is visible from the next cycle.
- Icon select: the lowest index i whose pixel is non-zero and not blanked wins. If no icon wins, the output is palette[world_pixel].
- Blanking, with blink compiled in: icon i is blanked when blink_mask[i]=1 and blink_phase=0.
- Stage 1 (registered): the winning colour, the one-hot winner vector and video_on.
- Stage 2 (registered): when the delayed video_on=1, the outputs take the stage-1 colour and winner. Otherwise the outputs are 0 and icon_hit is 0.
- Reset: all pipeline registers clear, so VGA_R/G/B=0 and icon_hit=0. The palette returns to its defaults; blink_cnt=0 and blink_phase=1 (visible).
- Reset asserted mid-frame clears everything on the next edge. The first valid output appears 2 cycles after reset deasserts.

## Timing
- Latency: exactly 2 clk cycles from inputs (including video_on) to VGA_*/icon_hit. The DTG sync signals must be delayed by 2 cycles externally.
- Throughput: one pixel per cycle, with no stalls.
- Blink counter: counts 0..BLINK_PERIOD-1 every cycle, regardless of video_on. At the wrap it returns to 0 and blink_phase toggles. The first toggle to 0 occurs BLINK_PERIOD cycles after reset.
- Changing blink_mask takes effect on the pixel sampled in that same cycle.

## Configuration
- COLORIZER_BLINK_EN defined: the blink counter, blink_phase and the blanking logic are present.
- COLORIZER_BLINK_EN undefined: no counter is built, blink_mask is ignored and every icon is always eligible. Latency, reset values and all other behaviour are unchanged.

## Structure
- Shared package colorizer_pkg holds the default palette constants (PAL_WHITE, PAL_BLACK, PAL_BROWN, PAL_GREEN) and the NUM_ICONS limit.
- One sub-module, colorizer_palette, contains the palette register file with its write port and combinational read. The priority select and pipeline stay in colorizer_mc.

## Test plan
- Reset, then world_pixel=2, icons all 0, video_on=1 -> RGB=0x840 and icon_hit=0, appearing exactly 2 cycles after input.
- icon0=0x00F and icon1=0xF00 together -> 0x00F with icon_hit=01; icon0=0 -> 0xF00 with icon_hit=10.
- video_on=0 with non-zero icons -> RGB=0 and icon_hit=0 two cycles later; stage-1 contents are discarded.
- Write 0x123 to palette[0] while world_pixel=0 in the same cycle:
  - that pixel shows 0xFFF;
  - the next pixel shows 0x123;
  - after reset it returns to 0xFFF.
- With BLINK_PERIOD=4 and COLORIZER_BLINK_EN defined, blink_mask=01, icon0=0x0F0 and world 0:
  - output alternates 0x0F0 for 4 cycles and 0xFFF for 4 cycles;
  - without the macro, 0x0F0 is output constantly.
- Assert reset for one cycle mid-stream -> outputs are 0 for 2 cycles, then resume correct colours.

Source files
------------

// File: rtl/colorizer_pkg.sv
// Shared constants for the colorizer: icon-count limit and the default
// world-map palette, written as 4-bit-per-channel colours.
package colorizer_pkg;
  localparam int MAX_ICONS = 8;

  localparam logic [11:0] PAL_WHITE = 12'hFFF;
  localparam logic [11:0] PAL_BLACK = 12'h000;
  localparam logic [11:0] PAL_BROWN = 12'h840;
  localparam logic [11:0] PAL_GREEN = 12'h0F0;

  function automatic logic [11:0] pal_default4(input int idx);
    case (idx)
      0:       return PAL_WHITE;
      1:       return PAL_BLACK;
      2:       return PAL_BROWN;
      3:       return PAL_GREEN;
      default: return 12'h000;
    endcase
  endfunction
endpackage

// File: rtl/colorizer_palette.sv
// World-map palette: 2**WORLD_W registers, one write port, combinational read.
// A same-cycle write to the read address is seen from the following cycle.
module colorizer_palette
  import colorizer_pkg::*;
#(
  parameter int COLOR_W = 4,
  parameter int WORLD_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [WORLD_W-1:0]     waddr,
  input  logic [3*COLOR_W-1:0]   wdata,
  input  logic [WORLD_W-1:0]     raddr,
  output logic [3*COLOR_W-1:0]   rdata
);
  localparam int DEPTH = 1 << WORLD_W;
  localparam int PIX_W = 3 * COLOR_W;

  // Left-justify each 4-bit channel into COLOR_W bits.
  function automatic logic [PIX_W-1:0] widen(input logic [11:0] c);
    logic [PIX_W-1:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int b = 0; b < COLOR_W; b++) begin
        int src;
        src = b + 4 - COLOR_W;
        if (src >= 0 && src < 4) r[ch*COLOR_W + b] = c[ch*4 + src];
      end
    return r;
  endfunction

  logic [PIX_W-1:0] pal_q [DEPTH];
  logic [PIX_W-1:0] pal_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) pal_d[i] = pal_q[i];
    if (we) pal_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pal_q[i] <= widen(pal_default4(i));
    end else begin
      for (int i = 0; i < DEPTH; i++) pal_q[i] <= pal_d[i];
    end
  end

  assign rdata = pal_q[raddr];
endmodule

// File: rtl/colorizer_mc.sv
// Two-stage pixel colorizer: priority icon merge over a palette-mapped world
// pixel. Define COLORIZER_BLINK_EN to build the per-icon blink logic.
module colorizer_mc
  import colorizer_pkg::*;
#(
  parameter int NUM_ICONS    = 2,
  parameter int COLOR_W      = 4,
  parameter int WORLD_W      = 2,
  parameter int BLINK_PERIOD = 25_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           video_on,
  input  logic [WORLD_W-1:0]             world_pixel,
  input  logic [NUM_ICONS*3*COLOR_W-1:0] icon_pixels,
  input  logic [NUM_ICONS-1:0]           blink_mask,
  input  logic                           pal_we,
  input  logic [WORLD_W-1:0]             pal_addr,
  input  logic [3*COLOR_W-1:0]           pal_wdata,
  output logic [COLOR_W-1:0]             VGA_R,
  output logic [COLOR_W-1:0]             VGA_G,
  output logic [COLOR_W-1:0]             VGA_B,
  output logic [NUM_ICONS-1:0]           icon_hit
);
  localparam int PIX_W = 3 * COLOR_W;

  logic [PIX_W-1:0]     pal_rd;
  logic [NUM_ICONS-1:0] blank;
  logic [NUM_ICONS-1:0] eligible;
  logic [PIX_W-1:0]     s1_col_d, s1_col_q, out_col_d, out_col_q;
  logic [NUM_ICONS-1:0] s1_hit_d, s1_hit_q, out_hit_d, out_hit_q;
  logic                 s1_vld_d, s1_vld_q;

  colorizer_palette #(.COLOR_W(COLOR_W), .WORLD_W(WORLD_W)) u_pal (
    .clk   (clk),
    .reset (reset),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_wdata),
    .raddr (world_pixel),
    .rdata (pal_rd)
  );

`ifdef COLORIZER_BLINK_EN
  localparam int CNT_W = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_PERIOD - 1);

  logic [CNT_W-1:0] blink_cnt_d, blink_cnt_q;
  logic             blink_phase_d, blink_phase_q;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blank = blink_phase_q ? '0 : blink_mask;
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blank = '0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_ICONS; i++)
      eligible[i] = (|icon_pixels[i*PIX_W +: PIX_W]) && !blank[i];
  end

  // Lowest eligible index wins; otherwise the palette-mapped world pixel.
  always_comb begin
    logic found;
    found    = 1'b0;
    s1_hit_d = '0;
    s1_col_d = pal_rd;
    for (int i = 0; i < NUM_ICONS; i++) begin
      if (!found && eligible[i]) begin
        found       = 1'b1;
        s1_hit_d[i] = 1'b1;
        s1_col_d    = icon_pixels[i*PIX_W +: PIX_W];
      end
    end
    s1_vld_d = video_on;
  end

  always_comb begin
    out_col_d = s1_vld_q ? s1_col_q : '0;
    out_hit_d = s1_vld_q ? s1_hit_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_col_q  <= '0;
      s1_hit_q  <= '0;
      s1_vld_q  <= 1'b0;
      out_col_q <= '0;
      out_hit_q <= '0;
    end else begin
      s1_col_q  <= s1_col_d;
      s1_hit_q  <= s1_hit_d;
      s1_vld_q  <= s1_vld_d;
      out_col_q <= out_col_d;
      out_hit_q <= out_hit_d;
    end
  end

  assign VGA_R    = out_col_q[3*COLOR_W-1 -: COLOR_W];
  assign VGA_G    = out_col_q[2*COLOR_W-1 -: COLOR_W];
  assign VGA_B    = out_col_q[COLOR_W-1   -: COLOR_W];
  assign icon_hit = out_hit_q;
endmodule

// File: tb/tb_colorizer_mc.sv
// Randomized + directed bench for colorizer_mc against a cycle-level model.
module tb_colorizer_mc;
  localparam int NI = 2;
  localparam int CW = 4;
  localparam int WW = 2;
  localparam int BP = 4;

  logic            clk = 0;
  logic            reset = 1;
  logic            video_on = 0;
  logic [WW-1:0]   world_pixel = '0;
  logic [NI*12-1:0] icon_pixels = '0;
  logic [NI-1:0]   blink_mask = '0;
  logic            pal_we = 0;
  logic [WW-1:0]   pal_addr = '0;
  logic [11:0]     pal_wdata = '0;
  logic [CW-1:0]   VGA_R, VGA_G, VGA_B;
  logic [NI-1:0]   icon_hit;

  colorizer_mc #(.NUM_ICONS(NI), .COLOR_W(CW), .WORLD_W(WW), .BLINK_PERIOD(BP)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .world_pixel(world_pixel),
    .icon_pixels(icon_pixels), .blink_mask(blink_mask), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .icon_hit(icon_hit)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: palette contents, cycles since reset, and a two-deep
  // queue of pixels in flight (colour, hit, video_on).
  logic [11:0] pal_m [4];
  int          since_rst = 0;
  logic [11:0] q_col [$];
  logic [NI-1:0] q_hit [$];
  logic        q_vid [$];
  logic [11:0] exp_col = '0;
  logic [NI-1:0] exp_hit = '0;

  function automatic bit visible();
`ifdef COLORIZER_BLINK_EN
    return ((since_rst / BP) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic cycle();
    logic [11:0] col;
    logic [NI-1:0] hit;
    col = pal_m[world_pixel];
    hit = '0;
    for (int i = NI-1; i >= 0; i--) begin
      logic [11:0] ic;
      ic = icon_pixels[i*12 +: 12];
      if (ic != 0 && !(blink_mask[i] && !visible())) begin
        col = ic;
        hit = '0;
        hit[i] = 1'b1;
      end
    end
    @(posedge clk);
    if (reset) begin
      pal_m[0] = 12'hFFF; pal_m[1] = 12'h000; pal_m[2] = 12'h840; pal_m[3] = 12'h0F0;
      since_rst = 0;
      q_col.delete(); q_hit.delete(); q_vid.delete();
      exp_col = '0; exp_hit = '0;
    end else begin
      if (pal_we) pal_m[pal_addr] = pal_wdata;
      since_rst++;
      if (q_vid.size() > 0) begin
        exp_col = q_vid[0] ? q_col[0] : 12'h0;
        exp_hit = q_vid[0] ? q_hit[0] : '0;
        void'(q_col.pop_front()); void'(q_hit.pop_front()); void'(q_vid.pop_front());
      end else begin
        exp_col = '0; exp_hit = '0;
      end
      q_col.push_back(col); q_hit.push_back(hit); q_vid.push_back(video_on);
    end
    #1;
    chk("rgb", {20'h0, VGA_R, VGA_G, VGA_B}, {20'h0, exp_col});
    chk("hit", {30'h0, icon_hit}, {30'h0, exp_hit});
  endtask

  task automatic set_px(input logic vid, input logic [1:0] w, input logic [11:0] i0, input logic [11:0] i1);
    video_on = vid; world_pixel = w; icon_pixels = {i1, i0};
  endtask

  initial begin
    // Reset and reset-state outputs.
    reset = 1; cycle(); cycle();
    chk("rst_rgb", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    reset = 0;

    // World pixel via palette, 2-cycle latency.
    set_px(1, 2, 12'h000, 12'h000); cycle();
    set_px(0, 0, 12'h000, 12'h000); cycle();
    chk("map2_lat", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h840);
    cycle();

    // Icon priority.
    set_px(1, 1, 12'h00F, 12'hF00); cycle();
    set_px(1, 1, 12'h000, 12'hF00); cycle();
    chk("icon0_win", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h00F);
    chk("icon0_hit", {30'h0, icon_hit}, 32'h1);
    set_px(0, 1, 12'h00F, 12'hF00); cycle();
    chk("icon1_win", {20'h0, VGA_R, VGA_G, VGA_B}, 32'hF00);
    chk("icon1_hit", {30'h0, icon_hit}, 32'h2);
    cycle();
    chk("vid_off", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h0);

    // Palette write with same-cycle lookup.
    set_px(1, 0, 12'h000, 12'h000);
    pal_we = 1; pal_addr = 0; pal_wdata = 12'h123; cycle();
    pal_we = 0; cycle();
    chk("pal_old", {20'h0, VGA_R, VGA_G, VGA_B}, 32'hFFF);
    cycle();
    chk("pal_new", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h123);
    reset = 1; cycle(); reset = 0;
    cycle(); cycle();
    chk("pal_rst", {20'h0, VGA_R, VGA_G, VGA_B}, 32'hFFF);

    // Blink run from a fresh reset: icon0 masked, world 0.
    reset = 1; cycle(); reset = 0;
    blink_mask = 2'b01; set_px(1, 0, 12'h0F0, 12'h000);
    for (int k = 0; k < 20; k++) cycle();
    blink_mask = '0;

    // Randomized traffic with occasional palette writes and resets.
    for (int k = 0; k < 600; k++) begin
      video_on    = ($urandom_range(0, 9) < 8);
      world_pixel = WW'($urandom);
      for (int i = 0; i < NI; i++)
        icon_pixels[i*12 +: 12] = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'h000;
      blink_mask = NI'($urandom);
      pal_we     = ($urandom_range(0, 9) == 0);
      pal_addr   = WW'($urandom);
      pal_wdata  = 12'($urandom);
      reset      = ($urandom_range(0, 49) == 0);
      cycle();
    end
    reset = 0; pal_we = 0;
    cycle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
